// File: rtl/geri_yazma_hakemi.sv
// Write-back arbiter: one holding slot per result source, a single register-file write port.
// Define GERI_YAZMA_ACLIK_EN to add per-slot wait counters that lift starved slots above fixed priority.
module geri_yazma_hakemi #(
   parameter int KAYNAK_SAYISI    = 4,
   parameter int SOZCUK_GENISLIGI = 32,
   parameter int REGISTER_SAYISI  = 32,
   parameter int ACLIK_SINIRI     = 8
) (
   input  logic                                                   clk_i,
   input  logic                                                   rstn_i,
   input  logic [KAYNAK_SAYISI-1:0]                               kaynak_gecerli_i,
   output logic [KAYNAK_SAYISI-1:0]                               kaynak_hazir_o,
   input  logic [KAYNAK_SAYISI-1:0][$clog2(REGISTER_SAYISI)-1:0]  kaynak_rd_i,
   input  logic [KAYNAK_SAYISI-1:0][SOZCUK_GENISLIGI-1:0]         kaynak_veri_i,
   input  logic [KAYNAK_SAYISI-1:0]                               kaynak_fp_i,
   output logic [$clog2(REGISTER_SAYISI)-1:0]                     rd_o,
   output logic [SOZCUK_GENISLIGI-1:0]                            rd_veri_o,
   output logic                                                   rd_yaz_o,
   output logic                                                   rd_fp_yaz_o,
   input  logic [$clog2(REGISTER_SAYISI)-1:0]                     sorgu_rd_i,
   input  logic                                                   sorgu_fp_i,
   output logic                                                   sorgu_bekliyor_o
);

   localparam int K  = KAYNAK_SAYISI;
   localparam int W  = SOZCUK_GENISLIGI;
   localparam int RW = $clog2(REGISTER_SAYISI);

   if (K < 1) begin : g_kaynak_hatasi
      $error("KAYNAK_SAYISI must be at least 1");
   end
   if (ACLIK_SINIRI < 1) begin : g_aclik_hatasi
      $error("ACLIK_SINIRI must be at least 1");
   end

   logic [K-1:0]         dolu;
   logic [K-1:0][RW-1:0] slot_rd;
   logic [K-1:0][W-1:0]  slot_veri;
   logic [K-1:0]         slot_fp;

   logic [K-1:0]         secildi;
   logic                 sec_var;
   logic [RW-1:0]        sec_rd;
   logic [W-1:0]         sec_veri;
   logic                 sec_fp;
   logic [K-1:0]         kabul;
   logic                 eslesme;

`ifdef GERI_YAZMA_ACLIK_EN
   localparam int BW = $clog2(ACLIK_SINIRI + 1);

   logic [K-1:0][BW-1:0] bekleme;
   logic [K-1:0]         aclik;

   always_comb begin
      aclik = '0;
      for (int k = 0; k < K; k++) begin
         aclik[k] = dolu[k] && (bekleme[k] >= BW'(ACLIK_SINIRI));
      end
   end

   // Counter saturates at the limit so a starved slot stays eligible until served.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bekleme <= '0;
      end else begin
         for (int k = 0; k < K; k++) begin
            if (!dolu[k] || secildi[k]) begin
               bekleme[k] <= '0;
            end else if (bekleme[k] < BW'(ACLIK_SINIRI)) begin
               bekleme[k] <= bekleme[k] + BW'(1);
            end
         end
      end
   end
`endif

   always_comb begin : hakem
      secildi = '0;
      sec_var = 1'b0;
`ifdef GERI_YAZMA_ACLIK_EN
      for (int k = 0; k < K; k++) begin
         if (!sec_var && aclik[k]) begin
            secildi[k] = 1'b1;
            sec_var    = 1'b1;
         end
      end
`endif
      for (int k = 0; k < K; k++) begin
         if (!sec_var && dolu[k]) begin
            secildi[k] = 1'b1;
            sec_var    = 1'b1;
         end
      end
   end

   always_comb begin : secilen_mux
      sec_rd   = '0;
      sec_veri = '0;
      sec_fp   = 1'b0;
      for (int k = 0; k < K; k++) begin
         if (secildi[k]) begin
            sec_rd   = slot_rd[k];
            sec_veri = slot_veri[k];
            sec_fp   = slot_fp[k];
         end
      end
   end

   // A slot being drained this cycle can take a new entry on the same edge.
   assign kaynak_hazir_o = ~dolu | secildi;
   assign kabul          = kaynak_gecerli_i & kaynak_hazir_o;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dolu      <= '0;
         slot_rd   <= '0;
         slot_veri <= '0;
         slot_fp   <= '0;
      end else begin
         for (int k = 0; k < K; k++) begin
            if (kabul[k]) begin
               dolu[k]      <= 1'b1;
               slot_rd[k]   <= kaynak_rd_i[k];
               slot_veri[k] <= kaynak_veri_i[k];
               slot_fp[k]   <= kaynak_fp_i[k];
            end else if (secildi[k]) begin
               dolu[k] <= 1'b0;
            end
         end
      end
   end

   // Integer x0 is hardwired zero: the entry is retired without touching the port.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_o        <= '0;
         rd_veri_o   <= '0;
         rd_yaz_o    <= 1'b0;
         rd_fp_yaz_o <= 1'b0;
      end else begin
         rd_yaz_o <= 1'b0;
         if (sec_var && (sec_fp || (sec_rd != '0))) begin
            rd_o        <= sec_rd;
            rd_veri_o   <= sec_veri;
            rd_fp_yaz_o <= sec_fp;
            rd_yaz_o    <= 1'b1;
         end
      end
   end

   always_comb begin : tehlike_sorgu
      eslesme = 1'b0;
      for (int k = 0; k < K; k++) begin
         if (dolu[k] && (slot_rd[k] == sorgu_rd_i) && (slot_fp[k] == sorgu_fp_i)) begin
            eslesme = 1'b1;
         end
      end
      if (rd_yaz_o && (rd_o == sorgu_rd_i) && (rd_fp_yaz_o == sorgu_fp_i)) begin
         eslesme = 1'b1;
      end
      sorgu_bekliyor_o = eslesme && (sorgu_fp_i || (sorgu_rd_i != '0));
   end

endmodule

// File: tb/tb_geri_yazma_hakemi.sv
// Bench for geri_yazma_hakemi: directed scenarios, then random traffic against a per-source scoreboard.
module tb_geri_yazma_hakemi;
   localparam int K = 4, W = 32, RW = 5, LIM = 8;

   logic                 clk_i = 1'b0;
   logic                 rstn_i;
   logic [K-1:0]         kaynak_gecerli_i;
   logic [K-1:0]         kaynak_hazir_o;
   logic [K-1:0][RW-1:0] kaynak_rd_i;
   logic [K-1:0][W-1:0]  kaynak_veri_i;
   logic [K-1:0]         kaynak_fp_i;
   logic [RW-1:0]        rd_o;
   logic [W-1:0]         rd_veri_o;
   logic                 rd_yaz_o;
   logic                 rd_fp_yaz_o;
   logic [RW-1:0]        sorgu_rd_i;
   logic                 sorgu_fp_i;
   logic                 sorgu_bekliyor_o;

   geri_yazma_hakemi #(.KAYNAK_SAYISI(K), .SOZCUK_GENISLIGI(W), .REGISTER_SAYISI(32),
                       .ACLIK_SINIRI(LIM)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .kaynak_gecerli_i(kaynak_gecerli_i), .kaynak_hazir_o(kaynak_hazir_o),
      .kaynak_rd_i(kaynak_rd_i), .kaynak_veri_i(kaynak_veri_i), .kaynak_fp_i(kaynak_fp_i),
      .rd_o(rd_o), .rd_veri_o(rd_veri_o), .rd_yaz_o(rd_yaz_o), .rd_fp_yaz_o(rd_fp_yaz_o),
      .sorgu_rd_i(sorgu_rd_i), .sorgu_fp_i(sorgu_fp_i), .sorgu_bekliyor_o(sorgu_bekliyor_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit sb_en = 1'b0;

   typedef struct {
      int            src;
      logic [RW-1:0] rd;
      logic [W-1:0]  veri;
      logic          fp;
      int            hs_edge;
   } beklenen_t;

   beklenen_t sb[$];

   always @(posedge clk_i) cyc++;

   task automatic chk(input string ad, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", ad, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sur(input int k, input logic [RW-1:0] rd, input logic [W-1:0] v, input logic fp);
      kaynak_gecerli_i[k] = 1'b1;
      kaynak_rd_i[k]      = rd;
      kaynak_veri_i[k]    = v;
      kaynak_fp_i[k]      = fp;
   endtask

   // Monitor: each observed write must match the oldest outstanding entry of the source
   // encoded in the data's top two bits, and appear no earlier than one edge after handshake.
   always @(negedge clk_i) begin
      int src, idx;
      if (sb_en && rstn_i && rd_yaz_o) begin
         src = int'(rd_veri_o[W-1 -: 2]);
         idx = -1;
         foreach (sb[i]) if (idx < 0 && sb[i].src == src) idx = i;
         total++;
         if (idx < 0) begin
            bad++;
            $display("FAIL sb_unexpected: got write rd=%0d veri=%0h fp=%0d, want no write (nothing pending for src %0d)",
                     rd_o, rd_veri_o, rd_fp_yaz_o, src);
         end else begin
            if (sb[idx].rd !== rd_o || sb[idx].veri !== rd_veri_o || sb[idx].fp !== rd_fp_yaz_o ||
                cyc < sb[idx].hs_edge + 1) begin
               bad++;
               $display("FAIL sb_write: got rd=%0d veri=%0h fp=%0d edge=%0d, want rd=%0d veri=%0h fp=%0d edge>=%0d",
                        rd_o, rd_veri_o, rd_fp_yaz_o, cyc, sb[idx].rd, sb[idx].veri, sb[idx].fp,
                        sb[idx].hs_edge + 1);
            end
            sb.delete(idx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, seq;
      bit found;
      rstn_i = 1'b0;
      kaynak_gecerli_i = '0;
      kaynak_rd_i = '0;
      kaynak_veri_i = '0;
      kaynak_fp_i = '0;
      sorgu_rd_i = '0;
      sorgu_fp_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_yaz", rd_yaz_o, 0);
      chk("rst_rd", rd_o, 0);
      chk("rst_veri", rd_veri_o, 0);
      chk("rst_fp", rd_fp_yaz_o, 0);
      chk("rst_hazir", kaynak_hazir_o, 4'hF);
      chk("rst_sorgu", sorgu_bekliyor_o, 0);
      #2 rstn_i = 1'b1;
      tick();

      // Single result from source 1
      sur(1, 5, 32'hDEADBEEF, 1'b0);
      tick();
      kaynak_gecerli_i = '0;
      chk("tek_erken", rd_yaz_o, 0);
      tick();
      chk("tek_yaz", rd_yaz_o, 1);
      chk("tek_rd", rd_o, 5);
      chk("tek_veri", rd_veri_o, 32'hDEADBEEF);
      chk("tek_fp", rd_fp_yaz_o, 0);
      tick();
      chk("tek_son", rd_yaz_o, 0);

      // Collision: all four sources on one edge
      for (int k = 0; k < K; k++) sur(k, RW'(k + 1), 32'h100 + k, 1'b0);
      tick();
      kaynak_gecerli_i = '0;
      chk("coll_hazir3_0", kaynak_hazir_o[3], 0);
      for (int i = 0; i < K; i++) begin
         tick();
         chk("coll_yaz", rd_yaz_o, 1);
         chk("coll_rd", rd_o, i + 1);
         if (i < 2) chk("coll_hazir3", kaynak_hazir_o[3], 0);
         if (i == 3) chk("coll_hazir_bos", kaynak_hazir_o, 4'hF);
      end
      tick();
      chk("coll_son", rd_yaz_o, 0);

      // Starvation: source 0 busy every cycle, source 2 holds rd 9
      sur(0, 10, 32'h10, 1'b0);
      sur(2, 9, 32'h99, 1'b0);
      tick();
      kaynak_gecerli_i[2] = 1'b0;
      found = 1'b0;
      d = 0;
      while (!found && d < 20) begin
         kaynak_rd_i[0] = RW'(10 + (d % 8));
         tick();
         d++;
         if (rd_yaz_o && rd_o == 9 && !rd_fp_yaz_o) found = 1'b1;
      end
`ifdef GERI_YAZMA_ACLIK_EN
      chk("aclik_bulundu", found, 1);
      chk("aclik_gecikme", d, LIM + 1);
      kaynak_gecerli_i = '0;
`else
      chk("sabit_oncelik_bekler", found, 0);
      kaynak_gecerli_i = '0;
      d = 0;
      while (!found && d < 5) begin
         tick();
         d++;
         if (rd_yaz_o && rd_o == 9 && !rd_fp_yaz_o) found = 1'b1;
      end
      chk("sabit_oncelik_sonra", found, 1);
`endif
      repeat (4) tick();
      chk("aclik_bos", kaynak_hazir_o, 4'hF);

      // Zero register
      sur(0, 0, 32'h7, 1'b0);
      tick();
      sur(0, 0, 32'h7, 1'b1);
      sorgu_rd_i = 0;
      sorgu_fp_i = 1'b0;
      #1 chk("x0_sorgu", sorgu_bekliyor_o, 0);
      tick();
      kaynak_gecerli_i = '0;
      chk("x0_yazmaz", rd_yaz_o, 0);
      tick();
      chk("f0_yaz", rd_yaz_o, 1);
      chk("f0_fp", rd_fp_yaz_o, 1);
      chk("f0_rd", rd_o, 0);
      chk("f0_veri", rd_veri_o, 7);
      tick();
      chk("f0_son", rd_yaz_o, 0);

      // Hazard query
      sur(2, 3, 32'h33, 1'b1);
      tick();
      kaynak_gecerli_i = '0;
      sorgu_rd_i = 3;
      sorgu_fp_i = 1'b1;
      #1 chk("sorgu_fp", sorgu_bekliyor_o, 1);
      sorgu_fp_i = 1'b0;
      #1 chk("sorgu_int", sorgu_bekliyor_o, 0);
      sorgu_fp_i = 1'b1;
      tick();
      chk("sorgu_cikis", sorgu_bekliyor_o, 1);
      tick();
      chk("sorgu_gecti", sorgu_bekliyor_o, 0);

      // Reset mid-operation with three slots full
      sur(0, 1, 32'hA1, 1'b0);
      sur(1, 2, 32'hA2, 1'b0);
      sur(2, 4, 32'hA4, 1'b1);
      tick();
      kaynak_gecerli_i = '0;
      sorgu_rd_i = 2;
      sorgu_fp_i = 1'b0;
      #1 chk("rst2_once_sorgu", sorgu_bekliyor_o, 1);
      #1 rstn_i = 1'b0;
      #1;
      chk("rst2_yaz", rd_yaz_o, 0);
      chk("rst2_rd", rd_o, 0);
      chk("rst2_veri", rd_veri_o, 0);
      chk("rst2_fp", rd_fp_yaz_o, 0);
      chk("rst2_hazir", kaynak_hazir_o, 4'hF);
      chk("rst2_sorgu", sorgu_bekliyor_o, 0);
      #1 rstn_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst2_yazmaz", rd_yaz_o, 0);
      end

      // Random traffic against the scoreboard
      sb_en = 1'b1;
      seq = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk_i);
         for (int k = 0; k < K; k++) begin
            if (kaynak_gecerli_i[k] && kaynak_hazir_o[k] && (kaynak_fp_i[k] || kaynak_rd_i[k] != 0))
               sb.push_back('{src: k, rd: kaynak_rd_i[k], veri: kaynak_veri_i[k],
                              fp: kaynak_fp_i[k], hs_edge: cyc + 1});
         end
         @(posedge clk_i);
         #1;
         for (int k = 0; k < K; k++) begin
            kaynak_gecerli_i[k] = ($urandom_range(0, 99) < 60);
            kaynak_rd_i[k]      = ($urandom_range(0, 9) == 0) ? RW'(0) : RW'($urandom_range(0, 31));
            kaynak_fp_i[k]      = 1'($urandom_range(0, 1));
            kaynak_veri_i[k]    = {2'(k), 14'(seq), 16'($urandom)};
            seq++;
         end
      end
      @(negedge clk_i);
      for (int k = 0; k < K; k++) begin
         if (kaynak_gecerli_i[k] && kaynak_hazir_o[k] && (kaynak_fp_i[k] || kaynak_rd_i[k] != 0))
            sb.push_back('{src: k, rd: kaynak_rd_i[k], veri: kaynak_veri_i[k],
                           fp: kaynak_fp_i[k], hs_edge: cyc + 1});
      end
      @(posedge clk_i);
      #1 kaynak_gecerli_i = '0;
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk_i);
      chk("drain_bos", sb.size(), 0);
      repeat (3) tick();
      chk("drain_hazir", kaynak_hazir_o, 4'hF);
      chk("drain_yaz", rd_yaz_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
